ad_ip_jesd204_tpl_dac_sync_ctrl: RTL and testbench
==================================================

// Module: ad_ip_jesd204_tpl_dac_sync_ctrl
// PURPOSE
//  Sequences start-up of the JESD204 DAC transport layer: arms on software request,
//  waits for an external trigger edge (or a manual sync), drives the datapath sync
//  pulse, then waits for link_ready before unmuting.
//  Sits between the register map/trigger pins and the TPL core's dac_sync input and
//  channel enable gating. Flags a link-ready timeout.
// PARAMETERS
//  SYNC_PULSE_CYCLES  4     width of the dac_sync pulse in clk cycles (>=1)
//  READY_TIMEOUT      1024  max cycles in WAIT_READY before timeout (>=2)
//  CNT_WIDTH          16    width of sync_count (saturating)
// PORTS
//  clk          in   1          core clock; the only clock
//  reset        in   1          synchronous, active-high
//  arm          in   1          1-cycle pulse: arm for external trigger
//  disarm       in   1          1-cycle pulse: abandon armed state
//  manual_sync  in   1          1-cycle pulse: sync now, no trigger needed
//  ext_sync     in   1          external trigger level, already synchronised to clk
//  link_ready   in   1          link layer ready
//  timeout_clr  in   1          clears sticky timeout
//  dac_sync     out  1          sync pulse to TPL core (PN/DDS reset)
//  dac_run      out  1          datapath unmuted; gates channel enables
//  armed        out  1          high while in ARMED
//  timeout      out  1          sticky: link_ready not seen within READY_TIMEOUT
//  sync_count   out  CNT_WIDTH  number of SYNC entries, saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; dac_sync, dac_run, armed, timeout = 0; sync_count=0; ext_sync_d=0.
//  Edge detect: ext_sync_d <= ext_sync; trig = ext_sync & ~ext_sync_d (rising edge only).
//  Outputs are decoded from the registered state: one cycle from input event to output.
//  IDLE:       manual_sync -> SYNC; else arm -> ARMED. Both in same cycle: SYNC.
//  ARMED:      armed=1. disarm -> IDLE (wins over trig in same cycle); trig -> SYNC;
//              manual_sync -> SYNC; arm is ignored.
//  SYNC:       dac_sync=1 for exactly SYNC_PULSE_CYCLES cycles (down-counter loaded on
//              entry), then -> WAIT_READY. All request inputs ignored. sync_count +1 on
//              every entry, saturating.
//  WAIT_READY: cycle counter starts at 0 on entry. link_ready=1 -> RUN. Counter reaching
//              READY_TIMEOUT-1 with link_ready=0 -> timeout<=1, -> IDLE.
//              manual_sync -> SYNC (restarts sequence).
//  RUN:        dac_run=1. link_ready=0 -> WAIT_READY (dac_run drops next cycle, counter
//              restarts). manual_sync -> SYNC. arm -> ARMED (datapath muted until
//              trigger). Priority: manual_sync > link_ready drop > arm.
//  timeout:    set by WAIT_READY expiry, cleared by timeout_clr; set wins on collision.
//  Reset mid-operation: returns to IDLE next edge; dac_sync/dac_run drop immediately
//  after that edge; sync_count and timeout cleared.
//  Trigger level held high across ARMED entry does not fire; a new rising edge is required.
// TESTING
//  1 reset; arm@c0; ext_sync rises @c5 -> armed=1 c1..c5; dac_sync=1 c6..c9; sync_count=1.
//  2 after test 1 link_ready=1 @c12 -> dac_run=1 from c13; drop link_ready @c20 ->
//    dac_run=0 @c21, state WAIT_READY.
//  3 manual_sync, link_ready held 0 -> timeout=1 exactly READY_TIMEOUT cycles after
//    WAIT_READY entry, state IDLE; timeout_clr -> 0; collision with a set -> stays 1.
//  4 armed, disarm and ext_sync edge same cycle -> IDLE, no dac_sync, sync_count unchanged.
//  5 ext_sync held high before arm -> no sync; drop then raise -> sync fires.
//  6 force sync_count to 0xFFFE; 3 syncs -> 0xFFFF, no wrap; reset during SYNC pulse ->
//    dac_sync=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Start-up sequencer for the JESD204 DAC transport layer: arm/trigger or manual sync,
// dac_sync pulse, then wait for link_ready before unmuting the datapath.
module ad_ip_jesd204_tpl_dac_sync_ctrl #(
    parameter int unsigned SYNC_PULSE_CYCLES = 4,
    parameter int unsigned READY_TIMEOUT     = 1024,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic                 manual_sync,
    input  logic                 ext_sync,
    input  logic                 link_ready,
    input  logic                 timeout_clr,
    output logic                 dac_sync,
    output logic                 dac_run,
    output logic                 armed,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] sync_count
);

    localparam int unsigned TMR_MAX = (READY_TIMEOUT > SYNC_PULSE_CYCLES) ?
                                      READY_TIMEOUT : SYNC_PULSE_CYCLES;
    localparam int unsigned TW = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0]        PULSE_LOAD = TW'(SYNC_PULSE_CYCLES - 1);
    localparam logic [TW-1:0]        READY_LAST = TW'(READY_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT    = '1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARMED      = 3'd1,
        SYNC       = 3'd2,
        WAIT_READY = 3'd3,
        RUN        = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 ext_sync_dly_q, ext_sync_dly_d;
    logic                 dac_sync_q, dac_sync_d;
    logic                 dac_run_q, dac_run_d;
    logic                 armed_q, armed_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] sync_count_q, sync_count_d;
    logic                 trig;
    logic                 timeout_set;

    // Shared timer: counts down the sync pulse in SYNC, counts up the ready wait in WAIT_READY.
    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        timeout_set    = 1'b0;
        ext_sync_dly_d = ext_sync;
        trig           = ext_sync & ~ext_sync_dly_q;

        unique case (state_q)
            IDLE: begin
                if (manual_sync) begin
                    state_d = SYNC;
                    tmr_d   = PULSE_LOAD;
                end else if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (disarm) begin
                    state_d = IDLE;
                end else if (trig || manual_sync) begin
                    state_d = SYNC;
                    tmr_d   = PULSE_LOAD;
                end
            end
            SYNC: begin
                if (tmr_q == '0) begin
                    state_d = WAIT_READY;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            WAIT_READY: begin
                if (manual_sync) begin
                    state_d = SYNC;
                    tmr_d   = PULSE_LOAD;
                end else if (link_ready) begin
                    state_d = RUN;
                end else if (tmr_q == READY_LAST) begin
                    state_d     = IDLE;
                    timeout_set = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            RUN: begin
                if (manual_sync) begin
                    state_d = SYNC;
                    tmr_d   = PULSE_LOAD;
                end else if (!link_ready) begin
                    state_d = WAIT_READY;
                    tmr_d   = '0;
                end else if (arm) begin
                    state_d = ARMED;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase

        // Outputs track the next state so they are registered alongside it.
        dac_sync_d = (state_d == SYNC);
        dac_run_d  = (state_d == RUN);
        armed_d    = (state_d == ARMED);

        sync_count_d = sync_count_q;
        if ((state_d == SYNC) && (state_q != SYNC) && (sync_count_q != CNT_SAT)) begin
            sync_count_d = sync_count_q + CNT_WIDTH'(1);
        end

        timeout_d = timeout_q;
        if (timeout_clr) begin
            timeout_d = 1'b0;
        end
        if (timeout_set) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            tmr_q          <= '0;
            ext_sync_dly_q <= 1'b0;
            dac_sync_q     <= 1'b0;
            dac_run_q      <= 1'b0;
            armed_q        <= 1'b0;
            timeout_q      <= 1'b0;
            sync_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            ext_sync_dly_q <= ext_sync_dly_d;
            dac_sync_q     <= dac_sync_d;
            dac_run_q      <= dac_run_d;
            armed_q        <= armed_d;
            timeout_q      <= timeout_d;
            sync_count_q   <= sync_count_d;
        end
    end

    assign dac_sync   = dac_sync_q;
    assign dac_run    = dac_run_q;
    assign armed      = armed_q;
    assign timeout    = timeout_q;
    assign sync_count = sync_count_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Bench for ad_ip_jesd204_tpl_dac_sync_ctrl: directed start-up scenarios plus random
// stimulus checked against a mode/age reference model.
module tb_ad_ip_jesd204_tpl_dac_sync_ctrl;

    localparam int unsigned SPC = 4;
    localparam int unsigned RT  = 20;
    localparam int unsigned CW  = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    localparam int M_IDLE = 0, M_ARMED = 1, M_SYNC = 2, M_WAIT = 3, M_RUN = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0, disarm = 1'b0, manual_sync = 1'b0;
    logic          ext_sync = 1'b0, link_ready = 1'b0, timeout_clr = 1'b0;
    logic          dac_sync, dac_run, armed, timeout;
    logic [CW-1:0] sync_count;

    int checks = 0;
    int fails  = 0;

    // Reference model: current mode, cycles spent in it, sticky flag, sync entries.
    int   m_mode = M_IDLE;
    int   m_age  = 0;
    int   m_cnt  = 0;
    logic m_to   = 1'b0;
    logic m_prev = 1'b0;

    ad_ip_jesd204_tpl_dac_sync_ctrl #(
        .SYNC_PULSE_CYCLES(SPC),
        .READY_TIMEOUT    (RT),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .disarm     (disarm),
        .manual_sync(manual_sync),
        .ext_sync   (ext_sync),
        .link_ready (link_ready),
        .timeout_clr(timeout_clr),
        .dac_sync   (dac_sync),
        .dac_run    (dac_run),
        .armed      (armed),
        .timeout    (timeout),
        .sync_count (sync_count)
    );

    always #5 clk = ~clk;

    wire [CW+3:0] dut_vec = {dac_sync, dac_run, armed, timeout, sync_count};

    function automatic logic [CW+3:0] exp_vec();
        return {m_mode == M_SYNC, m_mode == M_RUN, m_mode == M_ARMED, m_to, CW'(m_cnt)};
    endfunction

    task automatic model_step();
        int   nm;
        logic set;
        logic trig;
        if (reset) begin
            m_mode = M_IDLE; m_age = 0; m_cnt = 0; m_to = 1'b0; m_prev = 1'b0;
            return;
        end
        trig = ext_sync && !m_prev;
        nm   = m_mode;
        set  = 1'b0;
        case (m_mode)
            M_IDLE:  if (manual_sync) nm = M_SYNC; else if (arm) nm = M_ARMED;
            M_ARMED: if (disarm) nm = M_IDLE; else if (trig || manual_sync) nm = M_SYNC;
            M_SYNC:  if (m_age == SPC - 1) nm = M_WAIT;
            M_WAIT: begin
                if (manual_sync) nm = M_SYNC;
                else if (link_ready) nm = M_RUN;
                else if (m_age == RT - 1) begin nm = M_IDLE; set = 1'b1; end
            end
            default: if (manual_sync) nm = M_SYNC; else if (!link_ready) nm = M_WAIT;
                     else if (arm) nm = M_ARMED;
        endcase
        if (nm == M_SYNC && m_mode != M_SYNC && m_cnt < CNT_MAX) m_cnt++;
        m_to   = set ? 1'b1 : (timeout_clr ? 1'b0 : m_to);
        m_age  = (nm == m_mode) ? m_age + 1 : 0;
        m_mode = nm;
        m_prev = ext_sync;
    endtask

    // Advance one clock: model sees the same inputs the DUT samples at this edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        arm = 1'b0; disarm = 1'b0; manual_sync = 1'b0; timeout_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (dut_vec !== '0) begin
            fails++; $display("FAIL reset_state: got %h expected %h", dut_vec, 8'h00);
        end
    endtask

    task automatic test_arm_trigger();
        arm = 1'b1;
        tick();
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (dut_vec !== {3'b001, 1'b0, 4'd0}) begin
                fails++; $display("FAIL armed_wait c%0d: got %h expected %h", c, dut_vec, 8'h20);
            end
            if (c == 5) ext_sync = 1'b1;
            tick();
        end
        for (int c = 6; c <= 9; c++) begin
            checks++;
            if (dut_vec !== {3'b100, 1'b0, 4'd1}) begin
                fails++; $display("FAIL sync_pulse c%0d: got %h expected %h", c, dut_vec, 8'h81);
            end
            tick();
        end
        checks++;
        if (dut_vec !== {4'b0000, 4'd1}) begin
            fails++; $display("FAIL sync_end c10: got %h expected %h", dut_vec, 8'h01);
        end
    endtask

    task automatic test_link_ready();
        for (int c = 10; c <= 20; c++) begin
            if (c == 12) link_ready = 1'b1;
            if (c == 20) link_ready = 1'b0;
            checks++;
            if (dac_run !== (c >= 13)) begin
                fails++; $display("FAIL run_gate c%0d: got %b expected %b", c, dac_run, c >= 13);
            end
            tick();
        end
        checks++;
        if (dut_vec !== {4'b0000, 4'd1} || dut_vec !== exp_vec()) begin
            fails++; $display("FAIL run_drop c21: got %h expected %h", dut_vec, 8'h01);
        end
    endtask

    task automatic test_timeout();
        manual_sync = 1'b1;
        tick();
        for (int k = 0; k < SPC; k++) tick();
        for (int k = 0; k < RT; k++) begin
            checks++;
            if (timeout !== 1'b0 || dut_vec !== exp_vec()) begin
                fails++; $display("FAIL timeout_early age%0d: got %h expected %h", k, dut_vec, exp_vec());
            end
            tick();
        end
        checks++;
        if ({dac_sync, dac_run, armed, timeout} !== 4'b0001) begin
            fails++; $display("FAIL timeout_set: got %b expected %b", {dac_sync, dac_run, armed, timeout}, 4'b0001);
        end
        timeout_clr = 1'b1;
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            fails++; $display("FAIL timeout_clr: got %b expected 0", timeout);
        end
        manual_sync = 1'b1;
        tick();
        for (int k = 0; k < SPC + RT - 1; k++) tick();
        timeout_clr = 1'b1;
        tick();
        checks++;
        if (timeout !== 1'b1 || armed !== 1'b0 || dac_sync !== 1'b0) begin
            fails++; $display("FAIL timeout_collision: got %b expected 1", timeout);
        end
    endtask

    task automatic test_disarm_collision();
        int cnt_before;
        ext_sync = 1'b0;
        tick();
        cnt_before = m_cnt;
        arm = 1'b1;
        tick(); tick();
        disarm = 1'b1; ext_sync = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({dac_sync, dac_run, armed} !== 3'b000 || sync_count !== CW'(cnt_before)) begin
                fails++; $display("FAIL disarm_wins k%0d: got %h expected cnt %0d no sync", k, dut_vec, cnt_before);
            end
            tick();
        end
    endtask

    task automatic test_held_trigger();
        int cnt_before;
        cnt_before = m_cnt;
        arm = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (dac_sync !== 1'b0 || armed !== 1'b1) begin
                fails++; $display("FAIL held_level k%0d: got sync %b armed %b expected 0 1", k, dac_sync, armed);
            end
            tick();
        end
        ext_sync = 1'b0;
        tick();
        ext_sync = 1'b1;
        tick();
        checks++;
        if (dac_sync !== 1'b1 || sync_count !== CW'(cnt_before + 1)) begin
            fails++; $display("FAIL new_edge: got sync %b cnt %0d expected 1 %0d", dac_sync, sync_count, cnt_before + 1);
        end
        ext_sync = 1'b0;
        for (int k = 0; k < SPC; k++) tick();
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 1; n <= CNT_MAX + 2; n++) begin
            manual_sync = 1'b1;
            tick();
            checks++;
            if (dac_sync !== 1'b1 || sync_count !== CW'((n > CNT_MAX) ? CNT_MAX : n)) begin
                fails++; $display("FAIL sat n%0d: got cnt %0d expected %0d", n, sync_count, (n > CNT_MAX) ? CNT_MAX : n);
            end
            for (int k = 0; k < SPC; k++) tick();
        end
        manual_sync = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (dut_vec !== '0) begin
            fails++; $display("FAIL reset_mid_sync: got %h expected %h", dut_vec, 8'h00);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            arm         = ($urandom_range(0, 15) == 0);
            disarm      = ($urandom_range(0, 15) == 0);
            manual_sync = ($urandom_range(0, 31) == 0);
            timeout_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) ext_sync = ~ext_sync;
            if ($urandom_range(0, 11) == 0) link_ready = ~link_ready;
            tick();
            reset = 1'b0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                fails++; $display("FAIL random i%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_arm_trigger();
        test_link_ready();
        test_timeout();
        test_disarm_collision();
        test_held_trigger();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
